// File: rtl/window_delta_buffer.sv
// Snapshots a running accumulator once per window and queues the modulo-2^WIDTH
// window deltas in a small FIFO drained over a valid/ready handshake.
module window_delta_buffer #(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 16,
  parameter int DEPTH  = 4,
  parameter int LVLW   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic [LVLW-1:0]  level
);

  localparam int CNTW = $clog2(WINDOW);
  localparam int PTRW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNTW-1:0]  r_counter;
  logic [CNTW-1:0]  w_counterNext;
  logic [WIDTH-1:0] r_baseline;
  logic [WIDTH-1:0] w_baselineNext;
  logic [WIDTH-1:0] w_delta;
  logic             w_push;
  logic             w_boundary;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_rdPtr;
  logic [PTRW-1:0]  r_wrPtr;
  logic [LVLW-1:0]  r_level;
  logic             r_overflow;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_pushOk;
  logic             w_drop;

  assign w_boundary = (r_counter == CNTW'(WINDOW - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_counter  <= '0;
      r_baseline <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_counter  <= w_counterNext;
      r_baseline <= w_baselineNext;
    end
  end

  // Borrow is dropped on purpose: the delta stays exact across accumulator wrap.
  always_comb begin
    w_stateNext    = r_state;
    w_counterNext  = r_counter;
    w_baselineNext = r_baseline;
    w_push         = 1'b0;
    w_delta        = acc_in - r_baseline;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_stateNext    = RUN;
          w_counterNext  = '0;
          w_baselineNext = acc_in;
        end
      end
      RUN: begin
        if (!enable) begin
          w_stateNext   = IDLE;
          w_counterNext = '0;
        end else if (w_boundary) begin
          w_counterNext  = '0;
          w_baselineNext = acc_in;
          w_push         = 1'b1;
        end else begin
          w_counterNext = r_counter + CNTW'(1);
        end
      end
      default: begin
        w_stateNext   = IDLE;
        w_counterNext = '0;
      end
    endcase
  end

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LVLW'(DEPTH));
  assign w_pop    = !w_empty && out_ready;
  // A same-edge pop frees the slot, so a push into a full FIFO is still taken.
  assign w_pushOk = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  always_ff @(posedge clock) begin
    if (w_pushOk && !reset) begin
      r_mem[r_wrPtr] <= w_delta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + PTRW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTRW'(1);
      end
      case ({w_pushOk, w_pop})
        2'b10:   r_level <= r_level + LVLW'(1);
        2'b01:   r_level <= r_level - LVLW'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rdPtr];
  assign overflow  = r_overflow;
  assign level     = r_level;

endmodule

// File: doc/window_delta_buffer.md
Name: window_delta_buffer

Overview:
- Downstream stage of the 16-bit feedback accumulator; consumes its registered running-sum output.
- Every WINDOW cycles it snapshots the accumulator and computes the window sum as a modulo-2^16 delta against the previous snapshot.
- Deltas go into a small FIFO and are drained over a valid/ready interface toward the reporting logic.
- Accumulator wrap-around is tolerated by construction.

Parameters:
WIDTH, 16, data width of acc_in, the delta and out_data.
WINDOW, 16, cycles per window; legal range 2..256.
DEPTH, 4, FIFO entries; power of two, at least 2.
LVLW, 3, width of level, equal to log2(DEPTH)+1.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  windowing runs while high.
acc_in  input  WIDTH  accumulator registered output.
out_data  output  WIDTH  FIFO head delta; 0 when FIFO empty.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts head this cycle.
overflow  output  1  sticky: a delta was dropped because the FIFO was full.
level  output  LVLW  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (clock edge with reset=1), values visible after that edge:
  - state=IDLE, counter=0, baseline=0.
  - FIFO emptied: level=0, out_valid=0, out_data=0.
  - overflow=0.
  - reset overrides all other inputs, including reset asserted mid-window or with the FIFO partly full.
- State machine, two states, IDLE and RUN:
  - IDLE with enable=1 at an edge: baseline<=acc_in, counter<=0, go to RUN. Call this edge t0.
  - IDLE with enable=0: hold.
  - RUN with enable=1: counter increments each edge.
  - Boundary: the edge where counter==WINDOW-1 is edge t0+WINDOW. On it:
    - delta=(acc_in-baseline) mod 2^WIDTH.
    - baseline<=acc_in and counter<=0, so there are no gap cycles between windows.
    - delta is pushed to the FIFO.
  - RUN with enable=0 at any edge: go to IDLE and discard the partial window. The FIFO and overflow are untouched. A boundary coinciding with enable=0 is discarded too.
- Arithmetic:
  - Unsigned subtraction, WIDTH bits, borrow ignored.
  - The result is correct whenever the true window sum is below 2^WIDTH, even if acc_in wrapped.
- FIFO:
  - Circular buffer of DEPTH entries with wrapping read/write pointers.
  - out_valid = (level != 0).
  - out_data is the head entry, or 0 when empty.
- Handshake:
  - Pop occurs when out_valid && out_ready at an edge.
  - out_ready is ignored when empty.
  - The consumer may hold out_ready high permanently.
- Push latency: a delta pushed at edge t is visible (out_valid=1, out_data=delta) right after edge t, i.e. one cycle after the acc_in sample.
- Simultaneous push and pop:
  - Both take effect and level is unchanged.
  - When full, the pop frees the slot, so the push is accepted and overflow is not set.
- Push when full without a pop:
  - The delta is dropped and overflow<=1.
  - overflow stays 1 until reset.
  - Existing entries and their order are preserved.
- Pop when empty: no effect; pointers are unchanged.

Test Plan:
- Accumulator fed in=1 from reset (acc_in = 0,1,2,...), enable=1, out_ready=1 -> first out_valid one edge after t0+16, out_data=0x0010; subsequent deltas 0x0010 every 16 cycles, level never above 1.
- acc_in starting at 0xFFF8 with in=1 (wraps mid-window) -> delta 0x0010. With in=0x1000 -> delta 0x0000 (16*0x1000 mod 2^16). Both cases overflow=0.
- out_ready=0, in=1, enable=1 for 5 windows -> level=4 after 4th boundary; overflow=1 after 5th boundary; raise out_ready -> four 0x0010 pops on consecutive cycles, then out_valid=0, out_data=0, overflow still 1.
- FIFO full with out_ready=1 asserted on the exact boundary edge -> pop and push both taken, level stays 4, overflow=0.
- Drop enable at counter=9 -> no push, state IDLE; re-raise enable -> new baseline, next delta after a full 16 cycles equals 0x0010.
- reset for one edge while RUN with level=2 and overflow=1 -> level=0, out_valid=0, out_data=0, overflow=0, IDLE; with enable held high, a new window starts on the first edge after reset deasserts.
